// File: rtl/interrupt_pkg.sv
// Shared types and limits for the interrupt controller and its arbiter.
package interrupt_pkg;

  localparam int unsigned MAX_CHANNELS = 16;

  typedef enum logic {
    FIXED       = 1'b0,
    ROUND_ROBIN = 1'b1
  } priority_mode_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } irq_state_t;

endpackage

// File: rtl/interrupt_controller_priority_arbiter.sv
// Combinational arbiter: picks one active request line.
// FIXED picks the highest index; ROUND_ROBIN searches upward from i_start with wrap.
module priority_arbiter
  import interrupt_pkg::*;
#(
  parameter int unsigned N     = 15,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  input  priority_mode_t   i_mode,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index
);

  logic [N-1:0] w_rot;

  // Rotate the requests so that bit 0 of w_rot is the i_start position.
  always_comb begin
    w_rot = N'({i_req, i_req} >> i_start);
  end

  // Select the winner according to the arbitration mode.
  always_comb begin
    int unsigned w_pos;
    o_valid = 1'b0;
    o_index = '0;
    w_pos   = 0;
    if (i_mode == FIXED) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i_req[i]) begin
          o_valid = 1'b1;
          o_index = IDX_W'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!o_valid && w_rot[i]) begin
          o_valid = 1'b1;
          w_pos   = 32'(i_start) + i;
          if (w_pos >= N) begin
            w_pos = w_pos - N;
          end
          o_index = IDX_W'(w_pos);
        end
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-detected, maskable interrupt controller with vectored acknowledge.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int unsigned    CHANNELS      = 15,
  parameter priority_mode_t PRIORITY_MODE = FIXED,
  parameter int unsigned    VEC_W         = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] interrupt_req,
  input  logic                interrupt_enable,
  input  logic                mask_we,
  input  logic [CHANNELS-1:0] mask_wdata,
  input  logic                clear_valid,
  input  logic [CHANNELS-1:0] clear_bits,
  input  logic                ack,
  output logic                irq,
  output logic                wake,
  output logic [VEC_W-1:0]    vector,
  output logic [CHANNELS-1:0] flags,
  output logic [CHANNELS-1:0] mask
);

  localparam logic [VEC_W-1:0] LAST_CH = VEC_W'(CHANNELS - 1);

  logic [CHANNELS-1:0] r_req_q;
  logic [CHANNELS-1:0] r_flags;
  logic [CHANNELS-1:0] r_mask;
  logic [VEC_W-1:0]    r_vector;
  logic [VEC_W-1:0]    r_ptr;
  irq_state_t          r_state;
  irq_state_t          w_state_nxt;

  logic [CHANNELS-1:0] w_edge;
  logic [CHANNELS-1:0] w_pending;
  logic                w_any;
  logic [VEC_W-1:0]    w_start;
  logic                w_win_valid;
  logic [VEC_W-1:0]    w_win_idx;
  logic                w_take;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_flags_nxt;

  // Edge detect, pending set and round-robin start position.
  always_comb begin
    w_edge    = interrupt_req & ~r_req_q;
    w_pending = r_flags & r_mask;
    w_any     = |w_pending;
    w_start   = (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;
  end

  priority_arbiter #(
    .N     (CHANNELS),
    .IDX_W (VEC_W)
  ) u_arb (
    .i_req   (w_pending),
    .i_start (w_start),
    .i_mode  (PRIORITY_MODE),
    .o_valid (w_win_valid),
    .o_index (w_win_idx)
  );

  // Flag update: software clear and ack clear, with a new edge overriding both.
  always_comb begin
    w_take = ack && w_win_valid;
    w_clr  = '0;
    if (clear_valid) begin
      w_clr = clear_bits;
    end
    if (w_take) begin
      w_clr = w_clr | (CHANNELS'(1) << w_win_idx);
    end
    w_flags_nxt = (r_flags & ~w_clr) | w_edge;
  end

  // Datapath registers: request sample, flags, mask, vector, round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_q  <= '0;
      r_flags  <= '0;
      r_mask   <= '0;
      r_vector <= '0;
      r_ptr    <= LAST_CH;
    end else begin
      r_req_q <= interrupt_req;
      r_flags <= w_flags_nxt;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
      if (w_take) begin
        r_vector <= w_win_idx + 1'b1;
        r_ptr    <= w_win_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: PENDING while any enabled flag remains set.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)  w_state_nxt = PENDING;
      PENDING: if (!w_any) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    irq    = interrupt_enable & w_any;
    wake   = w_any;
    vector = r_vector;
    flags  = r_flags;
    mask   = r_mask;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: FIXED and ROUND_ROBIN instances share stimulus.
module tb_interrupt_controller;
  import interrupt_pkg::*;

  localparam int unsigned CH = 15;
  localparam int unsigned VW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] interrupt_req;
  logic          interrupt_enable;
  logic          mask_we;
  logic [CH-1:0] mask_wdata;
  logic          clear_valid;
  logic [CH-1:0] clear_bits;
  logic          ack;

  logic          f_irq, f_wake, r_irq, r_wake;
  logic [VW-1:0] f_vector, r_vector;
  logic [CH-1:0] f_flags, f_mask, r_flags, r_mask;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  interrupt_controller #(
    .CHANNELS      (CH),
    .PRIORITY_MODE (FIXED),
    .VEC_W         (VW)
  ) u_fix (
    .clk              (clk),
    .reset            (reset),
    .interrupt_req    (interrupt_req),
    .interrupt_enable (interrupt_enable),
    .mask_we          (mask_we),
    .mask_wdata       (mask_wdata),
    .clear_valid      (clear_valid),
    .clear_bits       (clear_bits),
    .ack              (ack),
    .irq              (f_irq),
    .wake             (f_wake),
    .vector           (f_vector),
    .flags            (f_flags),
    .mask             (f_mask)
  );

  interrupt_controller #(
    .CHANNELS      (CH),
    .PRIORITY_MODE (ROUND_ROBIN),
    .VEC_W         (VW)
  ) u_rr (
    .clk              (clk),
    .reset            (reset),
    .interrupt_req    (interrupt_req),
    .interrupt_enable (interrupt_enable),
    .mask_we          (mask_we),
    .mask_wdata       (mask_wdata),
    .clear_valid      (clear_valid),
    .clear_bits       (clear_bits),
    .ack              (ack),
    .irq              (r_irq),
    .wake             (r_wake),
    .vector           (r_vector),
    .flags            (r_flags),
    .mask             (r_mask)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset            = 1'b1;
    interrupt_req    = '0;
    interrupt_enable = 1'b0;
    mask_we          = 1'b0;
    mask_wdata       = '0;
    clear_valid      = 1'b0;
    clear_bits       = '0;
    ack              = 1'b0;
    step();
    step();
    chk("rst_flags",  32'(f_flags), 32'h0);
    chk("rst_mask",   32'(f_mask), 32'h0);
    chk("rst_vector", 32'(f_vector), 32'h0);
    chk("rst_irq",    32'(f_irq), 32'h0);
    chk("rst_wake",   32'(f_wake), 32'h0);

    // Enable all channels
    reset = 1'b0; interrupt_enable = 1'b1; mask_we = 1'b1; mask_wdata = 15'h7FFF;
    step();
    mask_we = 1'b0;
    chk("mask_all", 32'(f_mask), 32'h7FFF);

    // Single request on channel 0
    interrupt_req = 15'h0001;
    step();
    interrupt_req = '0;
    chk("ch0_flags", 32'(f_flags), 32'h0001);
    chk("ch0_irq",   32'(f_irq), 32'h1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    #1;
    chk("ch0_vec",     32'(f_vector), 32'h1);
    chk("ch0_flags_c", 32'(f_flags), 32'h0);
    chk("ch0_irq_low", 32'(f_irq), 32'h0);

    // Two simultaneous requests, highest first
    interrupt_req = 15'h4800;
    step();
    interrupt_req = '0;
    chk("dual_flags", 32'(f_flags), 32'h4800);
    ack = 1'b1;
    step();
    chk("dual_vec1",  32'(f_vector), 32'hF);
    chk("dual_left",  32'(f_flags), 32'h0800);
    step();
    ack = 1'b0;
    #1;
    chk("dual_vec2",  32'(f_vector), 32'hC);
    chk("dual_empty", 32'(f_flags), 32'h0);
    chk("dual_irq",   32'(f_irq), 32'h0);

    // Held-high request sets only once
    interrupt_req = 15'h0040;
    step();
    chk("held_flags", 32'(f_flags), 32'h0040);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("held_vec", 32'(f_vector), 32'h7);
    for (int i = 0; i < 20; i++) step();
    chk("held_noflag", 32'(f_flags), 32'h0);
    chk("held_noirq",  32'(f_irq), 32'h0);
    chk("held_vecsty", 32'(f_vector), 32'h7);
    interrupt_req = '0;
    step();

    // Wake vs irq, set-beats-clear
    interrupt_enable = 1'b0; mask_we = 1'b1; mask_wdata = 15'h0040;
    step();
    mask_we = 1'b0;
    interrupt_req = 15'h0040;
    step();
    chk("wake_hi",    32'(f_wake), 32'h1);
    chk("irq_gated",  32'(f_irq), 32'h0);
    interrupt_enable = 1'b1;
    #1;
    chk("irq_enabled", 32'(f_irq), 32'h1);
    interrupt_req = '0;
    step();
    interrupt_req = 15'h0040; clear_valid = 1'b1; clear_bits = 15'h0040;
    step();
    chk("set_wins", 32'(f_flags), 32'h0040);
    step();
    clear_valid = 1'b0; clear_bits = '0;
    chk("clear_ok", 32'(f_flags), 32'h0);
    interrupt_req = '0;
    step();

    // Masked-off edge still latches; unmask raises irq; empty ack keeps vector
    interrupt_req = 15'h0002;
    step();
    interrupt_req = '0;
    chk("masked_flag", 32'(f_flags), 32'h0002);
    chk("masked_wake", 32'(f_wake), 32'h0);
    chk("masked_irq",  32'(f_irq), 32'h0);
    mask_we = 1'b1; mask_wdata = 15'h7FFF;
    step();
    mask_we = 1'b0;
    chk("unmask_irq", 32'(f_irq), 32'h1);
    ack = 1'b1;
    step();
    chk("unmask_vec", 32'(f_vector), 32'h2);
    step();
    ack = 1'b0;
    chk("empty_ack_vec",   32'(f_vector), 32'h2);
    chk("empty_ack_flags", 32'(f_flags), 32'h0);

    // Reset dominates a full controller and a concurrent ack
    interrupt_req = 15'h7FFF;
    step();
    interrupt_req = '0;
    chk("full_flags", 32'(f_flags), 32'h7FFF);
    reset = 1'b1; ack = 1'b1;
    step();
    ack = 1'b0;
    chk("rst2_flags",  32'(f_flags), 32'h0);
    chk("rst2_mask",   32'(f_mask), 32'h0);
    chk("rst2_vector", 32'(f_vector), 32'h0);
    chk("rst2_irq",    32'(f_irq), 32'h0);

    // Request held through reset sets its flag on the first edge after
    interrupt_req = 15'h0008;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_flag", 32'(f_flags), 32'h0008);
    interrupt_req = '0;

    // Round robin alternation on the second instance
    reset = 1'b1;
    step();
    reset = 1'b0; mask_we = 1'b1; mask_wdata = 15'h7FFF; interrupt_enable = 1'b1;
    step();
    mask_we = 1'b0;
    chk("rr_rst_vec", 32'(r_vector), 32'h0);
    for (int i = 0; i < 4; i++) begin
      interrupt_req = 15'h0005;
      step();
      interrupt_req = '0;
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk($sformatf("rr_vec%0d", i), 32'(r_vector), (i % 2 == 0) ? 32'h1 : 32'h3);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter CHANNELS, default 15, number of interrupt request lines (legal 1..16).
REQ-002 SHALL have parameter PRIORITY_MODE, default FIXED, arbitration mode (FIXED: highest index wins; ROUND_ROBIN: rotating).
REQ-003 SHALL have parameter VEC_W, default 4, vector width (must satisfy 2**VEC_W > CHANNELS).
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port interrupt_req  input  CHANNELS  raw peripheral request lines, level, edge-detected internally.
REQ-007 SHALL have port interrupt_enable  input  1  CPU I flag.
REQ-008 SHALL have port mask_we  input  1  write strobe for mask register.
REQ-009 SHALL have port mask_wdata  input  CHANNELS  new mask value (1 = channel enabled).
REQ-010 SHALL have port clear_valid  input  1  factor-flag clear strobe.
REQ-011 SHALL have port clear_bits  input  CHANNELS  flags to clear when clear_valid.
REQ-012 SHALL have port ack  input  1  one-cycle pulse from core at interrupt dispatch.
REQ-013 SHALL have port irq  output  1  interrupt pending to core.
REQ-014 SHALL have port wake  output  1  halt release.
REQ-015 SHALL have port vector  output  VEC_W  winning channel index + 1, latched at ack.
REQ-016 SHALL have port flags  output  CHANNELS  factor flags for register readback.
REQ-017 SHALL have port mask  output  CHANNELS  current mask register.

Function
REQ-018 SHALL register interrupt_req each cycle; flag[i] set at the clock where req[i]=1 and previous sample=0; a request held high SHALL NOT re-set a cleared flag.
REQ-019 SHALL clear flag[i] when clear_valid and clear_bits[i]; simultaneous set and clear on same bit: set wins.
REQ-020 SHALL drive irq combinationally = interrupt_enable AND |(flags AND mask); irq therefore rises the cycle after the req edge is sampled.
REQ-021 SHALL drive wake = |(flags AND mask), independent of interrupt_enable.
REQ-022 FIXED mode: winner = highest index i with flags[i] AND mask[i].
REQ-023 ROUND_ROBIN mode: search starts at (last_acked+1) mod CHANNELS, ascending with wrap; last_acked resets to CHANNELS-1 (first search starts at 0).
REQ-024 On ack with a pending winner: vector <= winner+1, flag[winner] cleared same edge, round-robin pointer <= winner.
REQ-025 On ack with no pending masked flag: vector, flags, pointer unchanged.
REQ-026 vector SHALL hold its value between acks; arbitration continues for subsequent irq.
REQ-027 mask_we updates mask on the clock edge; flags SHALL latch regardless of mask; unmasking a set flag raises irq next cycle.
REQ-028 State machine IDLE -> PENDING (any masked flag) -> IDLE on ack draining last flag; PENDING persists while flags remain.
REQ-029 Masked-off edges SHALL still set flags (readable via flags).

Reset
REQ-030 On reset: flags=0, mask=0, vector=0, req sample register=0, round-robin pointer=CHANNELS-1, state IDLE; irq=0, wake=0.
REQ-031 req sample register cleared at reset, so a req high through reset SHALL set its flag on the first post-reset edge.
REQ-032 Reset asserted mid-ack SHALL dominate; no flag or vector update that cycle.

Structure
REQ-033 Package interrupt_pkg SHALL hold the priority_mode_t enum (FIXED, ROUND_ROBIN), irq_state_t, and MAX_CHANNELS=16.
REQ-034 Arbitration SHALL be a sub-module priority_arbiter (inputs: request vector, start pointer, mode; outputs: valid, index).

Verification
REQ-035 FIXED, mask=all, enable=1: req=0x0001 -> irq high next cycle; ack -> vector=0x1, flags=0, irq low.
REQ-036 FIXED: req=0x4800 same cycle -> ack -> vector=0xF; second ack -> vector=0xC.
REQ-037 req=0x0040 held high across ack and 20 cycles -> exactly one flag set, one ack serviced, irq stays low after.
REQ-038 enable=0, mask=0x0040, req=0x0040 -> wake=1, irq=0; enable=1 -> irq=1; clear_bits=0x0040 same cycle as new edge -> flag stays set.
REQ-039 ROUND_ROBIN: flags 0x0005 persistently re-edged -> successive acks give vectors 0x1, 0x3, 0x1, 0x3.
REQ-040 Reset asserted with flags=0x7FFF, mask=0x7FFF -> next cycle flags=0, mask=0, vector=0, irq=0.
